// File: rtl/rng_draw.sv
// Seedable xorshift RNG with a req/valid handshake. Draws an unbiased index in
// [0, RANGE) by rejection sampling, forcing an accept after MAX_TRIES rounds.
module rng_draw #(
  parameter int unsigned      WIDTH        = 32,
  parameter int unsigned      RANGE        = 52,
  parameter int unsigned      MAX_TRIES    = 8,
  parameter int unsigned      FREE_RUN     = 1,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = WIDTH'(1),
  localparam int unsigned     IDX_W        = $clog2(RANGE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             seed_we,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  output logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] value,
  output logic             biased,
  output logic [7:0]       rejects,
  output logic [WIDTH-1:0] state_out
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] STEP  = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

  // Largest multiple of RANGE that fits in WIDTH bits; states at or above it are rejected.
  localparam logic [WIDTH:0] SPAN  = {1'b1, {WIDTH{1'b0}}};
  localparam logic [WIDTH:0] LIMIT = (SPAN / (WIDTH+1)'(RANGE)) * (WIDTH+1)'(RANGE);

  logic [1:0]       fsm_q, fsm_d;
  logic [WIDTH-1:0] rng_q, rng_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             valid_q, valid_d;
  logic             biased_q, biased_d;
  logic [IDX_W-1:0] value_q, value_d;
  logic [7:0]       rejects_q, rejects_d;
  logic             accept;

  function automatic logic [WIDTH-1:0] xs_next(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] y;
    y = x;
    if (WIDTH == 64) begin
      y = y ^ (y << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
    end else begin
      y = y ^ (y << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
    end
    return y;
  endfunction

  assign accept = ({1'b0, rng_q} < LIMIT);

  always_comb begin
    fsm_d     = fsm_q;
    rng_d     = rng_q;
    tries_d   = tries_q;
    valid_d   = 1'b0;
    biased_d  = 1'b0;
    value_d   = value_q;
    rejects_d = rejects_q;
    if (seed_we) begin
      rng_d     = (seed_in == '0) ? SEED_DEFAULT : seed_in;
      fsm_d     = IDLE;
      tries_d   = '0;
      rejects_d = '0;
    end else begin
      case (fsm_q)
        IDLE: begin
          // The edge that consumes req does not free-run the state.
          if (req) begin
            fsm_d   = STEP;
            tries_d = '0;
          end else if (FREE_RUN != 0) begin
            rng_d = xs_next(rng_q);
          end
        end
        STEP: begin
          rng_d = xs_next(rng_q);
          fsm_d = CHECK;
        end
        CHECK: begin
          if (accept || (tries_q == TRY_W'(MAX_TRIES - 1))) begin
            valid_d  = 1'b1;
            value_d  = IDX_W'(rng_q % WIDTH'(RANGE));
            biased_d = ~accept;
            fsm_d    = IDLE;
          end else begin
            tries_d = tries_q + TRY_W'(1);
            if (rejects_q != 8'hFF) rejects_d = rejects_q + 8'd1;
            fsm_d = STEP;
          end
        end
        default: fsm_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q     <= IDLE;
      rng_q     <= SEED_DEFAULT;
      tries_q   <= '0;
      valid_q   <= 1'b0;
      biased_q  <= 1'b0;
      value_q   <= '0;
      rejects_q <= '0;
    end else begin
      fsm_q     <= fsm_d;
      rng_q     <= rng_d;
      tries_q   <= tries_d;
      valid_q   <= valid_d;
      biased_q  <= biased_d;
      value_q   <= value_d;
      rejects_q <= rejects_d;
    end
  end

  assign ready     = (fsm_q == IDLE);
  assign valid     = valid_q;
  assign value     = value_q;
  assign biased    = biased_q;
  assign rejects   = rejects_q;
  assign state_out = rng_q;

endmodule

// File: tb/tb_rng_draw.sv
// Bench for rng_draw: directed scenarios plus randomized draws against a
// behavioural draw model (xorshift32 + rejection sampling, RANGE=52).
module tb_rng_draw;

  localparam int unsigned MAXT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        seed_we = 1'b0;
  logic        req = 1'b0;
  logic [31:0] seed_in = '0;

  logic        d0_ready, d0_valid, d0_biased;
  logic [5:0]  d0_value;
  logic [7:0]  d0_rejects;
  logic [31:0] d0_state;
  logic        d1_ready, d1_valid, d1_biased;
  logic [5:0]  d1_value;
  logic [7:0]  d1_rejects;
  logic [31:0] d1_state;
  logic        d2_ready, d2_valid, d2_biased;
  logic [5:0]  d2_value;
  logic [7:0]  d2_rejects;
  logic [31:0] d2_state;

  rng_draw #(.FREE_RUN(0)) dut0 (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed_in(seed_in), .req(req),
    .ready(d0_ready), .valid(d0_valid), .value(d0_value), .biased(d0_biased),
    .rejects(d0_rejects), .state_out(d0_state));

  rng_draw #(.FREE_RUN(1)) dut1 (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed_in(seed_in), .req(req),
    .ready(d1_ready), .valid(d1_valid), .value(d1_value), .biased(d1_biased),
    .rejects(d1_rejects), .state_out(d1_state));

  rng_draw #(.FREE_RUN(0), .MAX_TRIES(1)) dut2 (
    .clk(clk), .reset(reset), .seed_we(seed_we), .seed_in(seed_in), .req(req),
    .ready(d2_ready), .valid(d2_valid), .value(d2_value), .biased(d2_biased),
    .rejects(d2_rejects), .state_out(d2_state));

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic [31:0] m_state;
  int unsigned m_rej;
  logic [63:0] lim;

  bit          d2_seen;
  logic [5:0]  d2_val;
  logic        d2_b;
  int          d2_n;

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] inv_shl(input logic [31:0] y, input int k);
    logic [31:0] x;
    x = y;
    for (int i = 0; i < 32; i++) x = y ^ (x << k);
    return x;
  endfunction

  function automatic logic [31:0] inv_shr(input logic [31:0] y, input int k);
    logic [31:0] x;
    x = y;
    for (int i = 0; i < 32; i++) x = y ^ (x >> k);
    return x;
  endfunction

  function automatic logic [31:0] inv_xs(input logic [31:0] y);
    return inv_shl(inv_shr(inv_shl(y, 5), 17), 13);
  endfunction

  // One complete draw from state s0: final state, value, forced-accept flag, rejections.
  function automatic void model_draw(input logic [31:0] s0, input int unsigned tries_max,
                                     output logic [31:0] s, output logic [31:0] v,
                                     output logic b, output int r);
    s = s0; v = 0; b = 0; r = 0;
    for (int t = 0; t < int'(tries_max); t++) begin
      s = xs(s);
      if ({32'd0, s} < lim || t == int'(tries_max) - 1) begin
        v = s % 32'd52;
        b = ({32'd0, s} >= lim);
        break;
      end
      r++;
    end
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_in = s; seed_we = 1'b1;
    step();
    seed_we = 1'b0;
    m_state = (s == 0) ? 32'd1 : s;
    m_rej = 0;
  endtask

  task automatic draw(input string tag);
    logic [31:0] es, ev;
    logic        eb;
    int          er, n;
    bit          got;
    model_draw(m_state, MAXT, es, ev, eb, er);
    req = 1'b1;
    step();
    req = 1'b0;
    check({tag, " ready_busy"}, {63'd0, d0_ready}, 64'd0);
    got = 0; n = 0; d2_seen = 0;
    while (!got && n < 40) begin
      step();
      n++;
      if (d2_valid) begin d2_seen = 1; d2_val = d2_value; d2_b = d2_biased; d2_n = n; end
      if (d0_valid) got = 1;
    end
    m_rej = (m_rej + er > 255) ? 255 : m_rej + er;
    check({tag, " latency"}, got ? 64'(n) : 64'hFFFF, 64'(2 + 2 * er));
    if (got) begin
      check({tag, " value"},   64'(d0_value),   64'(ev));
      check({tag, " biased"},  64'(d0_biased),  64'(eb));
      check({tag, " state"},   64'(d0_state),   64'(es));
      check({tag, " rejects"}, 64'(d0_rejects), 64'(m_rej));
      check({tag, " ready"},   64'(d0_ready),   64'd1);
    end
    m_state = es;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] s, s2, iter;
    logic [31:0] es, ev;
    logic        eb;
    int          er, c0, c1;
    logic [5:0]  v1;

    lim = ((64'd1 << 32) / 64'd52) * 64'd52;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst ready",   64'(d0_ready),   64'd1);
    check("rst valid",   64'(d0_valid),   64'd0);
    check("rst value",   64'(d0_value),   64'd0);
    check("rst biased",  64'(d0_biased),  64'd0);
    check("rst rejects", 64'(d0_rejects), 64'd0);
    check("rst state",   64'(d0_state),   64'd1);
    check("rst state1",  64'(d1_state),   64'd1);
    reset = 1'b0;

    // T1/T2: known first draws from seed 1
    load_seed(32'd1);
    draw("T1");
    check("T1 state_lit", 64'(d0_state), 64'h0004_2021);
    check("T1 value_lit", 64'(d0_value), 64'd21);
    draw("T2");
    check("T2 state_lit", 64'(d0_state), 64'h0408_0601);
    check("T2 value_lit", 64'(d0_value), 64'd5);
    check("T2 rej_lit",   64'(d0_rejects), 64'd0);

    // T3: first STEP lands on a rejected state; MAX_TRIES=1 instance forces accept
    load_seed(inv_xs(32'hFFFF_FFF0));
    draw("T3");
    check("T3 rej_lit",   64'(d0_rejects), 64'd1);
    check("T3 d2 seen",   64'(d2_seen),    64'd1);
    check("T3 d2 lat",    64'(d2_n),       64'd2);
    check("T3 d2 biased", 64'(d2_b),       64'd1);
    s = 32'hFFFF_FFF0;
    check("T3 d2 value",  64'(d2_val),     64'(s % 32'd52));
    check("T3 d2 rej",    64'(d2_rejects), 64'd0);

    // T6: reset while in CHECK
    req = 1'b1; step(); req = 1'b0;
    step();
    reset = 1'b1; step(); reset = 1'b0;
    check("T6 valid",   64'(d0_valid),   64'd0);
    check("T6 ready",   64'(d0_ready),   64'd1);
    check("T6 state",   64'(d0_state),   64'd1);
    check("T6 rejects", 64'(d0_rejects), 64'd0);
    check("T6 value",   64'(d0_value),   64'd0);
    step();
    check("T6 valid2",  64'(d0_valid),   64'd0);
    m_state = 32'd1; m_rej = 0;

    // T4: zero seed substitution, seed abort mid-draw, seed+req same cycle
    load_seed(32'd0);
    check("T4 zero seed", 64'(d0_state), 64'd1);
    s = $urandom() | 32'd1;
    req = 1'b1; step(); req = 1'b0;
    seed_in = s; seed_we = 1'b1; step(); seed_we = 1'b0;
    check("T4 abort ready", 64'(d0_ready), 64'd1);
    check("T4 abort state", 64'(d0_state), 64'(s));
    c0 = 0;
    repeat (6) begin step(); if (d0_valid) c0++; end
    check("T4 abort novalid", 64'(c0), 64'd0);
    check("T4 hold state",    64'(d0_state), 64'(s));
    s2 = $urandom() | 32'h8000_0000;
    seed_in = s2; seed_we = 1'b1; req = 1'b1; step(); seed_we = 1'b0; req = 1'b0;
    check("T4 drop ready", 64'(d0_ready), 64'd1);
    check("T4 drop state", 64'(d0_state), 64'(s2));
    c0 = 0;
    repeat (6) begin step(); if (d0_valid) c0++; end
    check("T4 drop novalid", 64'(c0), 64'd0);

    // T5: free-run instance
    load_seed(32'd1);
    repeat (10) step();
    iter = 32'd1;
    for (int i = 0; i < 10; i++) iter = xs(iter);
    check("T5 freerun state", 64'(d1_state), 64'(iter));
    check("T5 hold state",    64'(d0_state), 64'd1);
    model_draw(iter, MAXT, es, ev, eb, er);
    c0 = 0; c1 = 0; v1 = '0;
    req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i == 3) req = 1'b0;
      step();
      if (i == 0) check("T5 consume state", 64'(d1_state), 64'(iter));
      if (d1_valid) begin c1++; v1 = d1_value; end
      if (d0_valid) c0++;
    end
    check("T5 one valid", 64'(c1), 64'd1);
    check("T5 d0 one valid", 64'(c0), 64'd1);
    check("T5 value", 64'(v1), 64'(ev));

    // Randomized draws
    load_seed(32'd1);
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 15) == 0) begin
        s = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
        load_seed(s);
        check("rnd seed", 64'(d0_state), 64'(m_state));
      end
      draw("rnd");
      check("rnd range", 64'(d0_value < 6'd52), 64'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
